// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per cycle over WIDTH cycles, then a sign-fix/writeback cycle.
module iter_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t state, state_next;

  logic             accept_arith;
  logic             move_hi;
  logic             move_lo;

  logic [CNT_W-1:0] cnt;
  logic             is_div_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             dz_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;

  // Next-state and request decode
  always_comb begin
    state_next   = state;
    accept_arith = 1'b0;
    move_hi      = 1'b0;
    move_lo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              accept_arith = 1'b1;
              state_next   = S_CALC;
            end
            OP_MTHI: move_hi = 1'b1;
            OP_MTLO: move_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (cnt == LAST_ITER) state_next = S_FIX;
      end
      S_FIX: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      done  <= (state == S_FIX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept_arith || state == S_FIX) begin
      cnt <= '0;
    end else if (state == S_CALC) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Operand conditioning: the core works on magnitudes, signs are restored in FIX
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    op_signed = ~op[0];
    sign_a    = op_signed & a[WIDTH-1];
    sign_b    = op_signed & b[WIDTH-1];
    abs_a     = sign_a ? (~a + WIDTH'(1)) : a;
    abs_b     = sign_b ? (~b + WIDTH'(1)) : b;
  end

  // One iteration: shift-add multiply or restoring divide sharing p_hi/p_lo
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shl_rem;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  always_comb begin
    add_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_b} : {(WIDTH + 1){1'b0}});
    shl_rem  = {p_hi, p_lo[WIDTH-1]};
    sub_diff = shl_rem - {1'b0, mag_b};
    hi_step  = add_sum[WIDTH:1];
    lo_step  = {add_sum[0], p_lo[WIDTH-1:1]};
    if (is_div_q) begin
      if (!sub_diff[WIDTH]) begin
        hi_step = sub_diff[WIDTH-1:0];
        lo_step = {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = shl_rem[WIDTH-1:0];
        lo_step = {p_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= '0;
      mag_b     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
    end else if (accept_arith) begin
      is_div_q  <= op[1];
      neg_q     <= sign_a ^ sign_b;
      rem_neg_q <= sign_a;
      dz_q      <= (b == '0);
      a_q       <= a;
      mag_b     <= abs_b;
      p_hi      <= '0;
      p_lo      <= abs_a;
    end else if (state == S_CALC) begin
      p_hi <= hi_step;
      p_lo <= lo_step;
    end
  end

  // Sign correction and special cases applied at writeback
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod     = {p_hi, p_lo};
    prod_neg = ~prod + (2 * WIDTH)'(1);
    if (dz_q && is_div_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = rem_neg_q ? (~p_hi + WIDTH'(1)) : p_hi;
      res_lo = neg_q ? (~p_lo + WIDTH'(1)) : p_lo;
    end else begin
      res_hi = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      res_lo = neg_q ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (move_hi) hi <= a;
      if (move_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_iter_mdu.sv
// Directed bench for iter_mdu (WIDTH=32) with a scoreboard of expected {hi,lo}.
module tb_iter_mdu;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int op_idx = 0;
  logic [63:0] exp_q[$];

  iter_mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact arithmetic on 64-bit values, special cases stated explicitly
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    model = '0;
    case (o)
      OP_MULT:  model = 64'(sx * sy);
      OP_MULTU: model = ux * uy;
      OP_DIV: begin
        if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          model = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) model = {x, 32'hFFFF_FFFF};
        else model = {x % y, x / y};
      end
      default: model = '0;
    endcase
  endfunction

  // Issue one arithmetic op now; optionally inject an MTHI start at cycle 'inject' while busy
  task automatic run_arith(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input int inject);
    int cyc;
    int bcnt;
    logic [63:0] e;
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    op_idx++;
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    exp_q.push_back(model(o, av, bv));
    tick();
    start = 1'b0;
    op = 3'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
    bcnt = busy ? 1 : 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (inject != 0 && cyc == inject) begin
        start = 1'b1;
        op = OP_MTHI;
        a = 32'd9;
      end else if (inject != 0 && cyc == inject + 1) begin
        start = 1'b0;
      end
      tick();
      cyc++;
      if (busy) bcnt++;
      if (cyc == 16) begin
        check($sformatf("op%0d_hold_hi", op_idx), 64'(hi), 64'(hi0));
        check($sformatf("op%0d_hold_lo", op_idx), 64'(lo), 64'(lo0));
      end
    end
    start = 1'b0;
    check($sformatf("op%0d_latency", op_idx), 64'(cyc), 64'd33);
    check($sformatf("op%0d_busy_cycles", op_idx), 64'(bcnt), 64'd33);
    e = exp_q.pop_front();
    check($sformatf("op%0d_hi", op_idx), 64'(hi), 64'(e[63:32]));
    check($sformatf("op%0d_lo", op_idx), 64'(lo), 64'(e[31:0]));
  endtask

  initial begin
    int dcnt;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    op = OP_NOP;
    a = '0;
    b = '0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    tick();

    // Spec vectors, issued back to back in each done cycle
    run_arith(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    run_arith(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    run_arith(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_arith(OP_DIVU, 32'd7, 32'd0, 0);
    run_arith(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    check("div_ovf_hi_const", 64'(hi), 64'd0);
    run_arith(OP_DIV, 32'hFFFF_FF00, 32'd0, 0);
    run_arith(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0);
    run_arith(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
    tick();

    // Mixed operands with idle gaps
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 20)) : 32'($urandom));
      run_arith(ro, ra, rb, 0);
      if (i % 2 == 1) begin
        tick();
        tick();
      end
    end

    // MTHI while busy is ignored; MTHI/MTLO in idle move without done
    tick();
    run_arith(OP_MULTU, 32'd2, 32'd3, 5);
    check("inject_hi", 64'(hi), 64'd0);
    check("inject_lo", 64'(lo), 64'd6);
    start = 1'b1;
    op = OP_MTHI;
    a = 32'd9;
    tick();
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'd9);
    check("mthi_lo", 64'(lo), 64'd6);
    check("mthi_busy", 64'(busy), 64'd0);
    tick();
    check("mthi_done", 64'(done), 64'd0);
    start = 1'b1;
    op = OP_MTLO;
    a = 32'h1234_5678;
    tick();
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234_5678);
    check("mtlo_hi", 64'(hi), 64'd9);
    tick();
    check("mtlo_done", 64'(done), 64'd0);

    // No-op code with start
    start = 1'b1;
    op = OP_NOP;
    a = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    tick();
    check("nop_busy", 64'(busy), 64'd0);
    check("nop_done", 64'(done), 64'd0);
    check("nop_hilo", {32'(hi), 32'(lo)}, {32'd9, 32'h1234_5678});

    // Reset in the middle of a divide discards it
    start = 1'b1;
    op = OP_DIVU;
    a = 32'd100;
    b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("midrst_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("midrst_no_done", 64'(dcnt), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);

    // Reset wins over a simultaneous start
    rst_n = 1'b0;
    start = 1'b1;
    op = OP_MTHI;
    a = 32'd5;
    tick();
    check("rst_prio_hi", 64'(hi), 64'd0);
    op = OP_MULTU;
    tick();
    check("rst_prio_busy", 64'(busy), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    run_arith(OP_DIVU, 32'd100, 32'd7, 0);
    run_arith(OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
